gray_frame_writer: RTL and testbench

- Sits directly downstream of the image-processing stage.
- Consumes its 12-bit decimated grayscale pixel stream (data plus valid strobe) and tracks pixel position within a frame.
- Tags each pixel with start-of-frame and end-of-line flags.
- Buffers tagged words in a small FIFO and presents them to the SDRAM write path over a valid/ready handshake, reporting frame completion and overflow.

---
 rtl/gray_frame_writer.sv | 170 +++++++++++++++++
 tb/tb_gray_frame_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_writer.sv
// gray_frame_writer: tags a decimated grayscale pixel stream with sof/eol, buffers it in a FIFO
// and hands it to the SDRAM write path. Optional GRAY_FRAME_WRITER_FRAME_CNT_EN adds frame_count.
module gray_frame_writer #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic              frame_done,
   output logic              fifo_overflow,
   output logic              busy
`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_count
`endif
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = AW + 1;
   localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
   localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     mem_q [FIFO_DEPTH];

   logic            fifo_full;
   logic            pop;
   logic            push;
   logic            pix_en;
   logic [XW-1:0]   cur_x;
   logic [YW-1:0]   cur_y;
   logic [15:0]     wr_word;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned
   // and no latch is inferred; combinational blocks use blocking assignments.
   always_comb begin
      fifo_full  = (occ_q == OCC_FULL);
      out_valid  = (occ_q != '0);
      pop        = out_valid && out_ready;
      pix_en     = in_valid && ((state_q == ACTIVE) || ((state_q == IDLE) && frame_start));

      // A coincident frame_start makes this pixel the (0,0) pixel.
      cur_x      = frame_start ? '0 : x_q;
      cur_y      = frame_start ? '0 : y_q;

      wr_word              = '0;
      wr_word[15]          = (cur_x == '0) && (cur_y == '0);
      wr_word[14]          = (cur_x == X_LAST);
      wr_word[DATA_W-1:0]  = in_data;

      push       = pix_en && (!fifo_full || pop);
      ovf_d      = ovf_q || (pix_en && !push);

      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      frame_done = 1'b0;

      case (state_q)
         IDLE, ACTIVE: begin
            if (frame_start) begin
               state_d = ACTIVE;
               x_d     = '0;
               y_d     = '0;
            end
            // Counters advance on dropped pixels too, keeping frame geometry intact.
            if (pix_en) begin
               if (cur_x == X_LAST) begin
                  x_d = '0;
                  if (cur_y == Y_LAST) begin
                     y_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     y_d = cur_y + 1'b1;
                  end
               end else begin
                  x_d = cur_x + 1'b1;
               end
            end
         end
         DRAIN: begin
            // An empty FIFO implies out_valid is low, so no pop can be in flight.
            if (occ_q == '0) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      occ_d    = occ_q + OW'(push) - OW'(pop);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; validity comes from the reset
   // occupancy counter, and out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_overflow = ovf_q;
   assign busy          = (state_q != IDLE);

`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;

   always_comb begin
      fcnt_d = frame_done ? fcnt_q + 16'd1 : fcnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_gray_frame_writer.sv
// Scoreboard bench for gray_frame_writer: a pixel-index reference model predicts the word stream,
// occupancy and status flags; a separate monitor compares whatever the DUT presents.
module tb_gray_frame_writer;

   localparam int IMG_W      = 4;
   localparam int IMG_H      = 2;
   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int NPIX       = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              frame_start = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [15:0]       out_data;
   logic              frame_done;
   logic              fifo_overflow;
   logic              busy;
`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
   logic [15:0]       frame_count;
`endif

   gray_frame_writer #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .frame_start   (frame_start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .frame_done    (frame_done),
      .fifo_overflow (fifo_overflow),
      .busy          (busy)
`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
      ,
      .frame_count   (frame_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position is a linear pixel index, FIFO is just an occupancy count.
   logic [15:0] exp_q [$];
   logic [15:0] seen_q [$];
   int m_occ    = 0;
   int m_idx    = 0;
   int m_frames = 0;
   bit m_active = 0;
   bit m_drain  = 0;
   bit m_ovf    = 0;

   bit exp_chk    = 0;
   bit exp_valid  = 0;
   bit exp_busy   = 0;
   bit exp_done   = 0;
   bit exp_ovf    = 0;
   int exp_frames = 0;
   int done_pulses = 0;

   task automatic model_reset();
      m_occ    = 0;
      m_idx    = 0;
      m_frames = 0;
      m_active = 0;
      m_drain  = 0;
      m_ovf    = 0;
      exp_q.delete();
   endtask

   // Drive one cycle at the falling edge, predict the effect of the next rising edge.
   task automatic step(input bit r, input bit fs, input bit iv,
                       input logic [DATA_W-1:0] d, input bit rdy);
      bit          pop;
      bit          take;
      logic [15:0] w;
      rst         = r;
      frame_start = fs;
      in_valid    = iv;
      in_data     = d;
      out_ready   = rdy;

      exp_chk    = !r;
      exp_valid  = (m_occ > 0);
      exp_busy   = m_active || m_drain;
      exp_done   = m_drain && (m_occ == 0);
      exp_ovf    = m_ovf;
      exp_frames = m_frames;

      if (r) begin
         model_reset();
      end else begin
         pop = (m_occ > 0) && rdy;
         if (m_drain) begin
            if (m_occ == 0) begin
               m_drain  = 0;
               m_frames = (m_frames + 1) % 65536;
            end
         end else begin
            take = iv && (m_active || fs);
            if (fs) begin
               m_idx    = 0;
               m_active = 1;
            end
            if (take) begin
               w              = '0;
               w[15]          = (m_idx == 0);
               w[14]          = ((m_idx % IMG_W) == IMG_W - 1);
               w[DATA_W-1:0]  = d;
               if (m_occ < FIFO_DEPTH || pop) begin
                  exp_q.push_back(w);
                  m_occ++;
               end else begin
                  m_ovf = 1;
               end
               if (m_idx == NPIX - 1) begin
                  m_active = 0;
                  m_drain  = 1;
                  m_idx    = 0;
               end else begin
                  m_idx++;
               end
            end
         end
         if (pop) m_occ--;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(0, 0, 0, '0, rdy);
   endtask

   task automatic do_reset();
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
   endtask

   task automatic frame(input int first, input bit rdy);
      step(0, 1, 1, DATA_W'(first), rdy);
      for (int i = 1; i < NPIX; i++) step(0, 0, 1, DATA_W'(first + i), rdy);
   endtask

   // Monitor: samples mid-cycle, independent of the stimulus process.
   initial begin
      logic [15:0] w;
      forever begin
         @(negedge clk);
         #2;
         if (exp_chk) begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(exp_busy));
            check("frame_done", 32'(frame_done), 32'(exp_done));
            check("fifo_overflow", 32'(fifo_overflow), 32'(exp_ovf));
`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
            check("frame_count", 32'(frame_count), 32'(exp_frames));
`endif
            if (frame_done) done_pulses++;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("scoreboard_nonempty_on_pop", 32'(exp_q.size()), 32'd1);
               end else begin
                  w = exp_q.pop_front();
                  check("out_data", 32'(out_data), 32'(w));
                  seen_q.push_back(out_data);
               end
            end
         end
      end
   end

   logic [15:0] golden [8] = '{16'h8001, 16'h0002, 16'h0003, 16'h4004,
                               16'h0005, 16'h0006, 16'h0007, 16'h4008};

   initial begin
      @(negedge clk);

      // Full-rate frame: exact word sequence and a single frame_done.
      do_reset();
      seen_q.delete();
      done_pulses = 0;
      frame(1, 1);
      idle(4, 1);
      check("seq_len", 32'(seen_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < seen_q.size(); i++)
         check("seq_word", 32'(seen_q[i]), 32'(golden[i]));
      check("seq_done_pulses", 32'(done_pulses), 32'd1);
      check("seq_busy_after", 32'(busy), 32'd0);

      // Stalled sink: four words fit, the rest overflow.
      do_reset();
      frame(1, 0);
      idle(2, 0);
      check("stall_overflow", 32'(fifo_overflow), 32'd1);
      seen_q.delete();
      done_pulses = 0;
      idle(8, 1);
      check("stall_words", 32'(seen_q.size()), 32'd4);
      check("stall_done_pulses", 32'(done_pulses), 32'd1);
      check("stall_overflow_sticky", 32'(fifo_overflow), 32'd1);

      // Full FIFO with simultaneous pop and push: write accepted, still full afterwards.
      do_reset();
      step(0, 1, 1, 12'h001, 0);
      step(0, 0, 1, 12'h002, 0);
      step(0, 0, 1, 12'h003, 0);
      step(0, 0, 1, 12'h004, 0);
      step(0, 0, 1, 12'h005, 1);
      check("pushpop_no_overflow", 32'(fifo_overflow), 32'd0);
      step(0, 0, 1, 12'h006, 0);
      check("pushpop_still_full", 32'(fifo_overflow), 32'd1);
      step(0, 0, 1, 12'h007, 1);
      step(0, 0, 1, 12'h008, 1);
      idle(8, 1);

      // Reset mid-frame with three buffered words; pixels ignored until frame_start.
      do_reset();
      step(0, 1, 1, 12'h011, 0);
      step(0, 0, 1, 12'h012, 0);
      step(0, 0, 1, 12'h013, 0);
      seen_q.delete();
      step(1, 0, 1, 12'h014, 0);
      step(1, 0, 1, 12'h015, 0);
      step(0, 0, 1, 12'h016, 1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, DATA_W'(12'h020 + i), 1);
      check("rst_no_words", 32'(seen_q.size()), 32'd0);

      // frame_start after pixel 3 restarts the frame with a sof pixel.
      do_reset();
      seen_q.delete();
      done_pulses = 0;
      step(0, 1, 1, 12'h001, 1);
      step(0, 0, 1, 12'h002, 1);
      step(0, 0, 1, 12'h003, 1);
      step(0, 1, 1, 12'h004, 1);
      for (int i = 5; i <= 11; i++) step(0, 0, 1, DATA_W'(i), 1);
      idle(6, 1);
      check("restart_words", 32'(seen_q.size()), 32'd11);
      if (seen_q.size() > 3) check("restart_sof", 32'(seen_q[3]), 32'h8004);
      check("restart_done_pulses", 32'(done_pulses), 32'd1);

`ifdef GRAY_FRAME_WRITER_FRAME_CNT_EN
      do_reset();
      for (int f = 0; f < 3; f++) begin
         frame(16 * f, 1);
         idle(4, 1);
      end
      check("frame_count_three", 32'(frame_count), 32'd3);
      do_reset();
      check("frame_count_reset", 32'(frame_count), 32'd0);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 9) < 7, DATA_W'($urandom), $urandom_range(0, 9) < 6);
      end
      idle(40, 1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
